bus_arbiter_2to1: RTL and testbench



---
 rtl/bus_arbiter_2to1_pkg.sv | 16 +
 rtl/bus_arbiter_2to1_rr_arb2.sv | 49 ++++
 rtl/bus_arbiter_2to1.sv | 92 +++++++++
 tb/tb_bus_arbiter_2to1.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_2to1_pkg.sv
// Shared req/ack memory bus definitions: default widths, command encodings
// and the master identifier used by arbiters and demuxes on this bus.
package bus_arbiter_2to1_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic {
    MST0 = 1'b0,
    MST1 = 1'b1
  } mst_e;

endpackage

// File: rtl/bus_arbiter_2to1_rr_arb2.sv
// Two-way round-robin grant with request-phase lock.
// The grant is combinational from req and registered state only, so nothing
// from the slave ack path can reach the request path.
module rr_arb2
  import bus_arbiter_2to1_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       lock,     // request presented but not accepted this cycle
  input  logic       done,     // request accepted this cycle
  output mst_e       gnt
);

  logic locked;
  mst_e owner;
  mst_e last_gnt;

  // Grant selection: hold the owner while locked, otherwise round-robin on ties
  always_comb begin
    gnt = mst_e'(~last_gnt);
    if (locked) begin
      gnt = owner;
    end else if (req == 2'b01) begin
      gnt = MST0;
    end else if (req == 2'b10) begin
      gnt = MST1;
    end
  end

  // Lock and priority state. A cycle with no forwarded request (including the
  // owner abandoning its request) simply drops the lock and keeps last_gnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked   <= 1'b0;
      owner    <= MST0;
      last_gnt <= MST1;
    end else begin
      locked <= lock;
      if (lock) begin
        owner <= gnt;
      end
      if (done) begin
        last_gnt <= gnt;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_2to1.sv
// Two-master to one-slave arbiter for the req/ack memory bus. Requests pass
// through with zero latency; read data returns to the owning master one cycle
// after the read ack.
module bus_arbiter_2to1
  import bus_arbiter_2to1_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_cmd,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_cmd,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_req,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_cmd,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_ack,
  input  logic [DATA_W-1:0] s_rdata
);

  mst_e gnt;
  logic rd_pend;
  mst_e rd_owner;
  logic accept;
  logic rd_accept;

  assign accept    = s_req & s_ack;
  assign rd_accept = accept & (s_cmd == CMD_READ);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({m1_req, m0_req}),
    .lock  (s_req & ~s_ack),
    .done  (accept),
    .gnt   (gnt)
  );

  // Request path: forward the granted master, all-zero when nobody requests
  always_comb begin
    s_req   = 1'b0;
    s_addr  = '0;
    s_cmd   = CMD_READ;
    s_wdata = '0;
    if (m0_req | m1_req) begin
      if (gnt == MST0) begin
        s_req   = m0_req;
        s_addr  = m0_addr;
        s_cmd   = m0_cmd;
        s_wdata = m0_wdata;
      end else begin
        s_req   = m1_req;
        s_addr  = m1_addr;
        s_cmd   = m1_cmd;
        s_wdata = m1_wdata;
      end
    end
  end

  // Ack and read-return steering; response and new request may share a cycle
  always_comb begin
    m0_ack   = accept & (gnt == MST0);
    m1_ack   = accept & (gnt == MST1);
    m0_rdata = (rd_pend && rd_owner == MST0) ? s_rdata : '0;
    m1_rdata = (rd_pend && rd_owner == MST1) ? s_rdata : '0;
  end

  // Read-return tracking: one response cycle after each read ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend  <= 1'b0;
      rd_owner <= MST0;
    end else begin
      rd_pend <= rd_accept;
      if (rd_accept) begin
        rd_owner <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Directed self-checking bench for bus_arbiter_2to1.
module tb_bus_arbiter_2to1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_cmd, m0_ack;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_cmd, m1_ack;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        s_req, s_cmd, s_ack;
  logic [31:0] s_addr, s_wdata, s_rdata;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  bus_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_cmd(m0_cmd), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_cmd(m1_cmd), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_cmd(s_cmd), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata)
  );

  // Drive point: just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_addr = '0; m0_cmd = 0; m0_wdata = '0;
    m1_req = 0; m1_addr = '0; m1_cmd = 0; m1_wdata = '0;
    s_ack = 0; s_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    #3;
    n_chk++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL reset_s_req: got %0b want 0", s_req); end
    n_chk++; if (s_addr !== 32'h0) begin n_fail++; $display("FAIL reset_s_addr: got %h want 0", s_addr); end
    n_chk++; if ({m0_ack, m1_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_acks: got %b want 00", {m0_ack, m1_ack}); end
    n_chk++; if ({m0_rdata, m1_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", {m0_rdata, m1_rdata}); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_tie();
    logic [31:0] exp_addr [4] = '{32'h0000_0100, 32'h8000_0200, 32'h0000_0100, 32'h8000_0200};
    logic [1:0]  exp_ack  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      m0_req = 1; m0_addr = 32'h0000_0100; m0_cmd = 1; m0_wdata = 32'h11;
      m1_req = 1; m1_addr = 32'h8000_0200; m1_cmd = 1; m1_wdata = 32'h22;
      s_ack = 1;
      @(negedge clk);
      n_chk++; if (s_addr !== exp_addr[i]) begin n_fail++; $display("FAIL tie_addr[%0d]: got %h want %h", i, s_addr, exp_addr[i]); end
      n_chk++; if ({m1_ack, m0_ack} !== exp_ack[i]) begin n_fail++; $display("FAIL tie_ack[%0d]: got %b want %b", i, {m1_ack, m0_ack}, exp_ack[i]); end
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_single_read();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      m0_req = (c < 3); m0_addr = 32'h0000_0010; m0_cmd = 0;
      s_ack = (c == 2);
      s_rdata = (c >= 3) ? 32'hDEAD_BEEF : 32'h0;
      @(negedge clk);
      n_chk++; if (m0_ack !== (c == 2)) begin n_fail++; $display("FAIL read_m0_ack[%0d]: got %0b want %0b", c, m0_ack, (c == 2)); end
      n_chk++; if (m0_rdata !== ((c == 3) ? 32'hDEAD_BEEF : 32'h0)) begin n_fail++; $display("FAIL read_m0_rdata[%0d]: got %h", c, m0_rdata); end
      n_chk++; if ({m1_ack, m1_rdata} !== 33'h0) begin n_fail++; $display("FAIL read_m1_quiet[%0d]: got ack %0b rdata %h want 0", c, m1_ack, m1_rdata); end
      if (c < 3) begin
        n_chk++; if ({s_req, s_addr, s_cmd} !== {1'b1, 32'h0000_0010, 1'b0}) begin n_fail++; $display("FAIL read_s_fwd[%0d]: got req %0b addr %h cmd %0b", c, s_req, s_addr, s_cmd); end
      end
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    // Prime: m0 served once so an unlocked tie would now favour m1
    tick();
    m0_req = 1; m0_addr = 32'h40; m0_cmd = 1; m0_wdata = 32'h1;
    s_ack = 1;
    @(negedge clk);
    n_chk++; if (m0_ack !== 1'b1) begin n_fail++; $display("FAIL lock_prime_ack: got %0b want 1", m0_ack); end
    for (int c = 0; c < 7; c++) begin
      tick();
      m0_req = (c < 6); m0_addr = 32'h40; m0_cmd = 1; m0_wdata = 32'h1234_5678;
      m1_req = (c >= 2); m1_addr = 32'h8000_0200; m1_cmd = 1; m1_wdata = 32'h9;
      s_ack = (c >= 5);
      @(negedge clk);
      if (c < 6) begin
        n_chk++; if ({s_addr, s_wdata} !== {32'h40, 32'h1234_5678}) begin n_fail++; $display("FAIL lock_hold[%0d]: got addr %h wdata %h want 40/12345678", c, s_addr, s_wdata); end
        n_chk++; if ({m1_ack, m0_ack} !== {1'b0, (c == 5)}) begin n_fail++; $display("FAIL lock_acks[%0d]: got %b", c, {m1_ack, m0_ack}); end
      end else begin
        n_chk++; if ({s_addr, m1_ack, m0_ack} !== {32'h8000_0200, 2'b10}) begin n_fail++; $display("FAIL lock_m1_next: got addr %h acks %b want 80000200/10", s_addr, {m1_ack, m0_ack}); end
      end
      n_chk++; if ({m0_rdata, m1_rdata} !== 64'h0) begin n_fail++; $display("FAIL lock_no_rdata[%0d]: got %h want 0", c, {m0_rdata, m1_rdata}); end
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_overlap();
    do_reset();
    tick();
    m0_req = 1; m0_addr = 32'h20; m0_cmd = 0;
    s_ack = 1;
    @(negedge clk);
    n_chk++; if (m0_ack !== 1'b1) begin n_fail++; $display("FAIL ovl_read_ack: got %0b want 1", m0_ack); end
    tick();
    m0_req = 0;
    m1_req = 1; m1_addr = 32'h8000_0300; m1_cmd = 1; m1_wdata = 32'hCAFE_F00D;
    s_ack = 0; s_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    n_chk++; if (m0_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL ovl_m0_rdata: got %h want 0badf00d", m0_rdata); end
    n_chk++; if (m1_rdata !== 32'h0) begin n_fail++; $display("FAIL ovl_m1_rdata: got %h want 0", m1_rdata); end
    n_chk++; if ({s_req, s_cmd, s_addr, s_wdata} !== {2'b11, 32'h8000_0300, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL ovl_m1_fwd: got req %0b cmd %0b addr %h wdata %h", s_req, s_cmd, s_addr, s_wdata); end
    tick();
    s_ack = 1;
    @(negedge clk);
    n_chk++; if ({m1_ack, m0_ack} !== 2'b10) begin n_fail++; $display("FAIL ovl_m1_ack: got %b want 10", {m1_ack, m0_ack}); end
    n_chk++; if (m0_rdata !== 32'h0) begin n_fail++; $display("FAIL ovl_m0_rdata_clear: got %h want 0", m0_rdata); end
    tick();
    m1_req = 0; s_ack = 0; s_rdata = 32'h7777_7777;
    @(negedge clk);
    n_chk++; if ({m0_rdata, m1_rdata} !== 64'h0) begin n_fail++; $display("FAIL ovl_write_no_resp: got %h want 0", {m0_rdata, m1_rdata}); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick();
    m0_req = 1; m0_addr = 32'h30; m0_cmd = 0;
    m1_req = 1; m1_addr = 32'h8000_0400; m1_cmd = 1;
    s_ack = 1;
    @(negedge clk);
    n_chk++; if ({m1_ack, m0_ack} !== 2'b01) begin n_fail++; $display("FAIL rmid_first_ack: got %b want 01", {m1_ack, m0_ack}); end
    tick();
    m0_req = 0; s_ack = 0; s_rdata = 32'h5555_AAAA;
    #2;
    n_chk++; if (m0_rdata !== 32'h5555_AAAA) begin n_fail++; $display("FAIL rmid_pending: got %h want 5555aaaa", m0_rdata); end
    rst_n = 0;
    #1;
    n_chk++; if ({m0_rdata, m1_rdata, m0_ack, m1_ack} !== 66'h0) begin n_fail++; $display("FAIL rmid_cleared: got rdata %h %h acks %b", m0_rdata, m1_rdata, {m1_ack, m0_ack}); end
    n_chk++; if ({s_req, s_addr} !== {1'b1, 32'h8000_0400}) begin n_fail++; $display("FAIL rmid_m1_follow: got req %0b addr %h", s_req, s_addr); end
    m0_req = 1; m0_cmd = 1;
    #1;
    n_chk++; if (s_addr !== 32'h30) begin n_fail++; $display("FAIL rmid_m0_pref: got %h want 30", s_addr); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    tick();
    s_ack = 1; s_rdata = 32'h0;
    @(negedge clk);
    n_chk++; if ({m1_ack, m0_ack, s_addr} !== {2'b01, 32'h30}) begin n_fail++; $display("FAIL rmid_after_release: got acks %b addr %h", {m1_ack, m0_ack}, s_addr); end
    n_chk++; if ({m0_rdata, m1_rdata} !== 64'h0) begin n_fail++; $display("FAIL rmid_stale: got %h want 0", {m0_rdata, m1_rdata}); end
    tick();
    idle_inputs();
  endtask

  task automatic test_illegal_drop();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      tick();
      m1_req = (c < 2); m1_addr = 32'h8000_0500; m1_cmd = 0;
      m0_req = (c >= 1); m0_addr = 32'h50; m0_cmd = 1;
      s_ack = (c == 3);
      @(negedge clk);
      case (c)
        0, 1: begin
          n_chk++; if ({s_req, s_addr} !== {1'b1, 32'h8000_0500}) begin n_fail++; $display("FAIL drop_m1_held[%0d]: got req %0b addr %h", c, s_req, s_addr); end
        end
        2: begin
          n_chk++; if ({s_req, m0_ack, m1_ack} !== 3'b000) begin n_fail++; $display("FAIL drop_nothing_fwd: got req %0b acks %b want 0", s_req, {m1_ack, m0_ack}); end
        end
        default: begin
          n_chk++; if ({s_req, s_addr, m1_ack, m0_ack} !== {1'b1, 32'h50, 2'b01}) begin n_fail++; $display("FAIL drop_m0_granted: got req %0b addr %h acks %b", s_req, s_addr, {m1_ack, m0_ack}); end
        end
      endcase
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no end of test want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tie();
    test_single_read();
    test_lock();
    test_overlap();
    test_reset_mid();
    test_illegal_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
